// File: rtl/cosine_sequencer.sv
// Control FSM for the cosine/distance datapath: drives the datapath state code and operands,
// then returns the captured distance over a valid/ready handshake. Watchdog: COSINE_SEQUENCER_WDOG_EN.
module cosine_sequencer #(
  parameter int ALERT_CYCLES = 4,
  parameter int MAX_ITER     = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_req,
  output logic        start_ack,
  input  logic [15:0] x_in,
  input  logic [15:0] v_in,
  output logic [3:0]  dp_state,
  output logic [15:0] xsig_out,
  output logic [15:0] vsig_out,
  input  logic        dp_stop,
  input  logic        dp_done,
  input  logic [15:0] dp_distance,
  output logic [15:0] distance_out,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic        alert,
  output logic        error,
  output logic [2:0]  dbgState,
  output logic [7:0]  dbgIter
);

  // Handshakes: start is accepted on a cycle with start_req & start_ack; a result transfers
  // (and result_valid clears) on a cycle with result_valid & result_ready.

  typedef enum logic [2:0] {
    IDLE, ALERT, START, ACCUM, REMULT, DIST, CAPTURE, ERROR
  } state_t;

  state_t      state, nextState;
  logic [7:0]  alertCnt, iterCnt, alertInc, iterInc;
  logic [15:0] xSig, vSig, distReg;
  logic        validReg, doneSeen, accept;

  assign alertInc  = (alertCnt == 8'hFF) ? alertCnt : alertCnt + 8'd1;
  assign iterInc   = (iterCnt == 8'hFF) ? iterCnt : iterCnt + 8'd1;
  assign start_ack = ((state == IDLE) && !validReg) || (state == ERROR);
  assign accept    = start_req && start_ack;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = ALERT;
      ALERT:   if (alertCnt >= 8'(ALERT_CYCLES - 1)) nextState = START;
      START:   nextState = ACCUM;
      ACCUM:   nextState = REMULT;
      REMULT: begin
        if (dp_stop) nextState = DIST;
`ifdef COSINE_SEQUENCER_WDOG_EN
        else if (iterInc >= 8'(MAX_ITER)) nextState = ERROR;
`endif
        else nextState = ACCUM;
      end
      DIST:    nextState = CAPTURE;
      CAPTURE: nextState = doneSeen ? IDLE : ERROR;
      ERROR:   if (accept) nextState = ALERT;
      default: nextState = IDLE;
    endcase
  end

  // The result is registered on the DIST exit edge so it is already valid during CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      alertCnt <= 8'd0;
      iterCnt  <= 8'd0;
      xSig     <= 16'd0;
      vSig     <= 16'd0;
      distReg  <= 16'd0;
      validReg <= 1'b0;
      doneSeen <= 1'b0;
    end else begin
      state <= nextState;
      if (validReg && result_ready) validReg <= 1'b0;
      if (accept) begin
        xSig     <= x_in;
        vSig     <= v_in;
        alertCnt <= 8'd0;
        iterCnt  <= 8'd0;
        doneSeen <= 1'b0;
      end
      if (state == ALERT) alertCnt <= alertInc;
      if (state == REMULT) iterCnt <= iterInc;
      if (state == DIST) begin
        doneSeen <= dp_done;
        if (dp_done) begin
          distReg  <= dp_distance;
          validReg <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    dp_state = 4'd0;
    case (state)
      ALERT:   dp_state = 4'd1;
      START:   dp_state = 4'd2;
      ACCUM:   dp_state = 4'd3;
      REMULT:  dp_state = 4'd5;
      DIST:    dp_state = 4'd4;
      default: dp_state = 4'd0;
    endcase
  end

  assign xsig_out     = xSig;
  assign vsig_out     = vSig;
  assign distance_out = distReg;
  assign result_valid = validReg;
  assign busy         = (state != IDLE) && (state != ERROR);
  assign alert        = (state == ALERT);
  assign error        = (state == ERROR);
  assign dbgState     = state;
  assign dbgIter      = iterCnt;

endmodule

// File: tb/tb_cosine_sequencer.sv
// Bench for cosine_sequencer: a timeline model of expected datapath codes per accept,
// a stub datapath, a per-cycle compare process and directed literal checks.
module tb_cosine_sequencer;

  localparam int A0 = 4;
  localparam int MAXI = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, startReq, resultReady;
  logic [15:0] xIn, vIn;
  int          stubMode;          // 0 nominal, 1 dp_stop never set, 2 dp_done never set
  logic [15:0] stubDist;

  logic        ack0, valid0, busy0, alert0, err0, stop0;
  logic [3:0]  dpState0;
  logic [15:0] xs0, vs0, dist0;
  logic [2:0]  dbgS0;
  logic [7:0]  dbgI0;
  logic        ack1, valid1, busy1, alert1, err1, stop1;
  logic [3:0]  dpState1;
  logic [15:0] xs1, vs1, dist1;
  logic [2:0]  dbgS1;
  logic [7:0]  dbgI1;
  logic        dpDone;

  cosine_sequencer #(.ALERT_CYCLES(A0), .MAX_ITER(MAXI)) u_dut0 (
    .clk(clk), .rst(rst), .start_req(startReq), .start_ack(ack0), .x_in(xIn), .v_in(vIn),
    .dp_state(dpState0), .xsig_out(xs0), .vsig_out(vs0), .dp_stop(stop0), .dp_done(dpDone),
    .dp_distance(stubDist), .distance_out(dist0), .result_valid(valid0),
    .result_ready(resultReady), .busy(busy0), .alert(alert0), .error(err0),
    .dbgState(dbgS0), .dbgIter(dbgI0));

  cosine_sequencer #(.ALERT_CYCLES(1), .MAX_ITER(MAXI)) u_dut1 (
    .clk(clk), .rst(rst), .start_req(startReq), .start_ack(ack1), .x_in(xIn), .v_in(vIn),
    .dp_state(dpState1), .xsig_out(xs1), .vsig_out(vs1), .dp_stop(stop1), .dp_done(dpDone),
    .dp_distance(stubDist), .distance_out(dist1), .result_valid(valid1),
    .result_ready(resultReady), .busy(busy1), .alert(alert1), .error(err1),
    .dbgState(dbgS1), .dbgIter(dbgI1));

  // Stub datapath: series completes on the 8th Remult visit after StartCalculation.
  logic [3:0] remCnt0, remCnt1;
  always @(posedge clk) begin
    if (dpState0 == 4'd2) remCnt0 <= 4'd0;
    else if (dpState0 == 4'd5 && remCnt0 != 4'hF) remCnt0 <= remCnt0 + 4'd1;
    if (dpState1 == 4'd2) remCnt1 <= 4'd0;
    else if (dpState1 == 4'd5 && remCnt1 != 4'hF) remCnt1 <= remCnt1 + 4'd1;
  end
  assign stop0  = (stubMode != 1) && (dpState0 == 4'd5) && (remCnt0 == 4'd7);
  assign stop1  = (stubMode != 1) && (dpState1 == 4'd5) && (remCnt1 == 4'd7);
  assign dpDone = (stubMode != 2);

  // Model: the code queue is the remaining timeline of dp_state values after an accept.
  int          codeQ[$];
  logic        validM, errM, errAtEnd;
  logic [15:0] distM, xM, vM;
  logic        wdogOn;
  int          cyc = 0;
  int          nCmp = 0, nBad = 0;
  logic        checkEn = 1'b0;

  initial begin
`ifdef COSINE_SEQUENCER_WDOG_EN
    wdogOn = 1'b1;
`else
    wdogOn = 1'b0;
`endif
  end

  function automatic logic [3:0] expCode();
    return (codeQ.size() != 0) ? 4'(codeQ[0]) : 4'd0;
  endfunction

  task automatic pushRun();
    int pairs;
    for (int i = 0; i < A0; i++) codeQ.push_back(1);
    codeQ.push_back(2);
    pairs = (stubMode == 1) ? (wdogOn ? MAXI : 200) : 8;
    for (int i = 0; i < pairs; i++) begin
      codeQ.push_back(3);
      codeQ.push_back(5);
    end
    if (stubMode != 1) begin
      codeQ.push_back(4);
      codeQ.push_back(0);
    end
    errAtEnd = (stubMode == 2) || (stubMode == 1 && wdogOn);
  endtask

  always @(posedge clk) begin
    logic ackM;
    int   c;
    cyc++;
    ackM = (codeQ.size() == 0) && !validM;
    if (rst) begin
      codeQ.delete();
      validM = 1'b0; errM = 1'b0; errAtEnd = 1'b0;
      distM = 16'd0; xM = 16'd0; vM = 16'd0;
    end else begin
      if (validM && resultReady) validM = 1'b0;
      if (codeQ.size() != 0) begin
        c = codeQ.pop_front();
        if (c == 4 && stubMode != 2) begin
          validM = 1'b1;
          distM  = stubDist;
        end
        if (codeQ.size() == 0 && errAtEnd) errM = 1'b1;
      end
      if (ackM && startReq) begin
        errM = 1'b0;
        xM = xIn;
        vM = vIn;
        pushRun();
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      check("dp_state", 16'(dpState0), 16'(expCode()));
      check("busy", 16'(busy0), 16'(codeQ.size() != 0));
      check("alert", 16'(alert0), 16'(expCode() == 4'd1));
      check("start_ack", 16'(ack0), 16'((codeQ.size() == 0) && !validM));
      check("error", 16'(err0), 16'(errM));
      check("result_valid", 16'(valid0), 16'(validM));
      check("distance_out", dist0, distM);
      check("xsig_out", xs0, xM);
      check("vsig_out", vs0, vM);
    end
  end

  task automatic waitValid0(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (valid0) break;
    end
    check(name, 16'(valid0), 16'd1);
  endtask

  initial begin
    int e0, lat0, lat1;
    logic inLoop;
    rst = 1'b1; startReq = 1'b0; resultReady = 1'b0;
    xIn = 16'd0; vIn = 16'd0; stubMode = 0; stubDist = 16'h0800;
    @(negedge clk);
    checkEn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 16'(dpState0), 16'd0);
    check("reset_valid", 16'(valid0), 16'd0);
    check("reset_dist", dist0, 16'h0000);

    // Reset and start in the same cycle: reset wins; the next accept measures latency.
    startReq = 1'b1; resultReady = 1'b1; vIn = 16'h0800;
    @(negedge clk);
    check("rst_wins_state0", 16'(dpState0), 16'd0);
    check("rst_wins_state1", 16'(dpState1), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    startReq = 1'b0;
    check("accept_alert", 16'(dpState0), 16'd1);
    e0 = cyc; lat0 = -1; lat1 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid1 && lat1 < 0) lat1 = cyc - e0;
      if (valid0 && lat0 < 0) begin
        lat0 = cyc - e0;
        check("first_dist", dist0, 16'h0800);
      end
    end
    check("latency_a4", 16'(lat0), 16'd22);
    check("latency_a1", 16'(lat1), 16'd19);

    // Result held while the consumer stalls, with start_req high throughout.
    resultReady = 1'b0; xIn = 16'h1234; vIn = 16'h0ABC; stubDist = 16'h5A5A;
    startReq = 1'b1;
    waitValid0(40, "hold_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_ack", 16'(ack0), 16'd0);
      check("hold_dist", dist0, 16'h5A5A);
      check("hold_state", 16'(dpState0), 16'd0);
    end
    resultReady = 1'b1;
    @(negedge clk);
    check("release_valid", 16'(valid0), 16'd0);
    check("release_ack", 16'(ack0), 16'd1);
    @(negedge clk);
    startReq = 1'b0;
    check("reaccept_alert", 16'(dpState0), 16'd1);
    check("reaccept_x", xs0, 16'h1234);
    waitValid0(40, "second_valid_timeout");
    @(negedge clk);

    // Reset in the middle of AccumulateTerms abandons the run.
    xIn = 16'h00F0; vIn = 16'h0F00;
    startReq = 1'b1;
    @(negedge clk);
    startReq = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("mid_accum", 16'(dpState0), 16'd3);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst = 1'b0;
    check("midrst_state", 16'(dpState0), 16'd0);
    check("midrst_busy", 16'(busy0), 16'd0);
    check("midrst_valid", 16'(valid0), 16'd0);
    check("midrst_dist", dist0, 16'h0000);

    // Missing dp_done sends the sequencer to ERROR after CalculateDistance.
    stubMode = 2; stubDist = 16'h7777;
    startReq = 1'b1;
    @(negedge clk);
    startReq = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (err0) break;
    end
    check("nodone_error", 16'(err0), 16'd1);
    check("nodone_valid", 16'(valid0), 16'd0);
    check("nodone_state", 16'(dpState0), 16'd0);
    stubMode = 0; stubDist = 16'h0321;
    startReq = 1'b1;
    @(negedge clk);
    startReq = 1'b0;
    check("error_exit", 16'(err0), 16'd0);
    check("error_exit_alert", 16'(dpState0), 16'd1);
    waitValid0(40, "recover_valid_timeout");
    check("recover_dist", dist0, 16'h0321);
    @(negedge clk);

    // dp_stop never asserted: watchdog fault when enabled, endless loop otherwise.
    stubMode = 1;
    startReq = 1'b1;
    @(negedge clk);
    startReq = 1'b0;
    for (int i = 0; i < 100; i++) @(negedge clk);
`ifdef COSINE_SEQUENCER_WDOG_EN
    check("wdog_error", 16'(err0), 16'd1);
    check("wdog_state", 16'(dpState0), 16'd0);
    stubMode = 0;
    startReq = 1'b1;
    @(negedge clk);
    startReq = 1'b0;
    check("wdog_exit", 16'(err0), 16'd0);
    check("wdog_alert", 16'(dpState0), 16'd1);
    waitValid0(40, "wdog_recover_timeout");
`else
    inLoop = (dpState0 == 4'd3) || (dpState0 == 4'd5);
    check("loop_busy", 16'(busy0), 16'd1);
    check("loop_state", 16'(inLoop), 16'd1);
    stubMode = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
